inst_buffer: RTL and testbench

Instruction queue between the 64-bit instruction SRAM read port and the dual-issue decode stage. It accepts up to two fetched instructions per cycle and presents the two oldest entries to decode. Decode retires 0, 1 or 2 entries per cycle. The buffer raises the fetch-side stall request (`stallreq_for_fifo`) when it cannot guarantee space, and it empties on pipeline flush.

---
 rtl/inst_buffer_if.sv | 39 +++
 rtl/inst_buffer.sv | 128 ++++++++++++
 tb/tb_inst_buffer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_buffer_if.sv
// Fetch/decode-facing bundle of the instruction buffer: push side from the
// instruction SRAM, pop/issue side toward dual-issue decode, plus control.
interface inst_buffer_if #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             stall;
  logic             push_valid;
  logic [PC_W-1:0]  push_pc;
  logic [1:0]       push_mask;
  logic [63:0]      push_inst;
  logic [1:0]       pop_cnt;

  logic             issue0_valid;
  logic [PC_W-1:0]  issue0_pc;
  logic [31:0]      issue0_inst;
  logic             issue1_valid;
  logic [PC_W-1:0]  issue1_pc;
  logic [31:0]      issue1_inst;
  logic             stallreq_for_fifo;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, stall, push_valid, push_pc, push_mask, push_inst, pop_cnt,
    input  issue0_valid, issue0_pc, issue0_inst,
    input  issue1_valid, issue1_pc, issue1_inst,
    input  stallreq_for_fifo, count
  );

  modport slave (
    input  flush, stall, push_valid, push_pc, push_mask, push_inst, pop_cnt,
    output issue0_valid, issue0_pc, issue0_inst,
    output issue1_valid, issue1_pc, issue1_inst,
    output stallreq_for_fifo, count
  );
endinterface

// File: rtl/inst_buffer.sv
// Circular instruction queue between 64-bit fetch and dual-issue decode.
// Optional same-cycle bypass of an empty/one-entry buffer: INST_BUF_BYPASS_EN.
module inst_buffer #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32
) (
  input  logic          clk,
  input  logic          rst,
  inst_buffer_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = PC_W + 32;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

`ifdef INST_BUF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Clamp a 0..2 request to what is actually available.
  function automatic logic [1:0] sat_pop(input logic [1:0] req, input logic [1:0] lim);
    return (req > lim) ? lim : req;
  endfunction

  function automatic logic [1:0] sat_cnt2(input logic [CNT_W-1:0] c);
    return (c >= CNT_W'(2)) ? 2'd2 : c[1:0];
  endfunction

  function automatic logic [1:0] word_cnt(input logic [1:0] mask);
    return {1'b0, mask[0]} + {1'b0, mask[1]};
  endfunction

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count_q;

  logic             stallreq;
  logic             push_acc;
  logic [1:0]       n_push;
  logic [PC_W-1:0]  pc_hi;
  logic [ENT_W-1:0] w0, w1;
  logic [ENT_W-1:0] st0, st1;
  logic [PTR_W-1:0] rd_ptr_nx1, wr_ptr_nx1;

  logic [ENT_W-1:0] iss0, iss1;
  logic             v0, v1;
  logic [1:0]       issue_cnt;
  logic [1:0]       pop_eff, pop_store, pop_push;
  logic [1:0]       n_write;
  logic [ENT_W-1:0] wdata_a;
  logic [CNT_W-1:0] count_nxt;

  assign stallreq   = (DEPTH_C - count_q) < CNT_W'(4);
  assign push_acc   = bus.push_valid && !stallreq;
  assign n_push     = push_acc ? word_cnt(bus.push_mask) : 2'd0;
  assign pc_hi      = bus.push_pc + PC_W'(4);
  // Compacted push words: w0 is the first valid word, w1 only exists for mask 11.
  assign w0         = bus.push_mask[0] ? {bus.push_pc, bus.push_inst[31:0]}
                                       : {pc_hi, bus.push_inst[63:32]};
  assign w1         = {pc_hi, bus.push_inst[63:32]};
  assign rd_ptr_nx1 = rd_ptr + PTR_W'(1);
  assign wr_ptr_nx1 = wr_ptr + PTR_W'(1);
  assign st0        = mem[rd_ptr];
  assign st1        = mem[rd_ptr_nx1];

  always_comb begin
    iss0 = st0;
    iss1 = st1;
    v0   = (count_q != '0);
    v1   = (count_q >= CNT_W'(2));
    if (BYPASS && push_acc) begin
      if (count_q == '0) begin
        iss0 = w0;
        iss1 = w1;
        v0   = (n_push != 2'd0);
        v1   = (n_push == 2'd2);
      end else if (count_q == CNT_W'(1)) begin
        iss1 = w0;
        v1   = (n_push != 2'd0);
      end
    end
  end

  // Pops are taken from stored entries first; any remainder consumes bypassed push words,
  // which are then never written.
  always_comb begin
    issue_cnt = {1'b0, v0} + {1'b0, v1};
    pop_eff   = bus.stall ? 2'd0 : sat_pop(bus.pop_cnt, issue_cnt);
    pop_store = sat_pop(pop_eff, sat_cnt2(count_q));
    pop_push  = pop_eff - pop_store;
    n_write   = n_push - pop_push;
    wdata_a   = (pop_push == 2'd0) ? w0 : w1;
    count_nxt = count_q + CNT_W'(n_write) - CNT_W'(pop_store);
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      rd_ptr  <= rd_ptr + PTR_W'(pop_store);
      wr_ptr  <= wr_ptr + PTR_W'(n_write);
      count_q <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !bus.flush) begin
      if (n_write != 2'd0) mem[wr_ptr] <= wdata_a;
      if (n_write == 2'd2) mem[wr_ptr_nx1] <= w1;
    end
  end

  // Invalid issue slots read as zero so unwritten storage never leaks out.
  assign bus.issue0_valid      = v0;
  assign bus.issue0_pc         = v0 ? iss0[ENT_W-1:32] : '0;
  assign bus.issue0_inst       = v0 ? iss0[31:0] : '0;
  assign bus.issue1_valid      = v1;
  assign bus.issue1_pc         = v1 ? iss1[ENT_W-1:32] : '0;
  assign bus.issue1_inst       = v1 ? iss1[31:0] : '0;
  assign bus.stallreq_for_fifo = stallreq;
  assign bus.count             = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) count_q <= DEPTH_C);
endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer (DEPTH=8): reset, compaction, fill/stall, flush, wrap, bypass.
module tb_inst_buffer;
  localparam int DEPTH = 8;
  localparam int PC_W  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_buffer_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();
  inst_buffer #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] pc_e;
  logic [31:0] lo_e;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] m,
                       input logic [63:0] inst, input logic [1:0] pop,
                       input logic st, input logic fl);
    bus.push_valid = v;
    bus.push_pc    = pc;
    bus.push_mask  = m;
    bus.push_inst  = inst;
    bus.pop_cnt    = pop;
    bus.stall      = st;
    bus.flush      = fl;
  endtask

  task automatic idle;
    drive(1'b0, 32'h0, 2'b00, 64'h0, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_v0", 64'(bus.issue0_valid), 64'd0);
    chk("rst_v1", 64'(bus.issue1_valid), 64'd0);
    chk("rst_pc0", 64'(bus.issue0_pc), 64'd0);
    chk("rst_inst0", 64'(bus.issue0_inst), 64'd0);
    chk("rst_pc1", 64'(bus.issue1_pc), 64'd0);
    chk("rst_inst1", 64'(bus.issue1_inst), 64'd0);
    chk("rst_stallreq", 64'(bus.stallreq_for_fifo), 64'd0);
    rst = 1'b0;

    // Basic dual push
    drive(1'b1, 32'hBFC00000, 2'b11, 64'h24020002_24010001, 2'd0, 1'b0, 1'b0);
    #1;
`ifdef INST_BUF_BYPASS_EN
    chk("byp_first_v0", 64'(bus.issue0_valid), 64'd1);
`else
    chk("lat_first_v0", 64'(bus.issue0_valid), 64'd0);
`endif
    tick();
    idle();
    chk("p11_count", 64'(bus.count), 64'd2);
    chk("p11_pc0", 64'(bus.issue0_pc), 64'hBFC00000);
    chk("p11_inst0", 64'(bus.issue0_inst), 64'h24010001);
    chk("p11_pc1", 64'(bus.issue1_pc), 64'hBFC00004);
    chk("p11_inst1", 64'(bus.issue1_inst), 64'h24020002);
    drive(1'b0, 32'h0, 2'b00, 64'h0, 2'd2, 1'b0, 1'b0);
    tick();
    idle();
    chk("pop2_count", 64'(bus.count), 64'd0);
    chk("pop2_v0", 64'(bus.issue0_valid), 64'd0);

    // High word only
    drive(1'b1, 32'hBFC00008, 2'b10, 64'h11111111_00000000, 2'd0, 1'b0, 1'b0);
    tick();
    idle();
    chk("m10_count", 64'(bus.count), 64'd1);
    chk("m10_pc0", 64'(bus.issue0_pc), 64'hBFC0000C);
    chk("m10_inst0", 64'(bus.issue0_inst), 64'h11111111);
    chk("m10_v1", 64'(bus.issue1_valid), 64'd0);
    drive(1'b0, 32'h0, 2'b00, 64'h0, 2'd1, 1'b0, 1'b0);
    tick();
    idle();
    chk("pop1_count", 64'(bus.count), 64'd0);

    // Over-pop must not underflow
    drive(1'b1, 32'h00000100, 2'b01, 64'h00000000_0000AAAA, 2'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 2'b00, 64'h0, 2'd2, 1'b0, 1'b0);
    tick();
    idle();
    chk("overpop_count", 64'(bus.count), 64'd0);
    chk("overpop_v0", 64'(bus.issue0_valid), 64'd0);

    // Fill until stall request (pointers start at 4, so this wraps)
    for (int k = 0; k < 3; k++) begin
      pc_e = 32'h1000 + 32'(8 * k);
      lo_e = 32'(2 * k);
      drive(1'b1, pc_e, 2'b11, {lo_e + 32'd1, lo_e}, 2'd0, 1'b0, 1'b0);
      tick();
      chk("fill_count", 64'(bus.count), 64'(2 * (k + 1)));
      chk("fill_stallreq", 64'(bus.stallreq_for_fifo), (k == 2) ? 64'd1 : 64'd0);
    end
    drive(1'b1, 32'h1018, 2'b11, 64'h7_00000006, 2'd0, 1'b0, 1'b0);
    tick();
    idle();
    chk("drop_count", 64'(bus.count), 64'd6);
    chk("drop_pc0", 64'(bus.issue0_pc), 64'h1000);

    drive(1'b0, 32'h0, 2'b00, 64'h0, 2'd2, 1'b1, 1'b0);
    tick();
    idle();
    chk("stall_count", 64'(bus.count), 64'd6);
    chk("stall_pc0", 64'(bus.issue0_pc), 64'h1000);

    drive(1'b0, 32'h0, 2'b00, 64'h0, 2'd2, 1'b0, 1'b0);
    tick();
    idle();
    chk("unfill_count", 64'(bus.count), 64'd4);
    chk("unfill_stallreq", 64'(bus.stallreq_for_fifo), 64'd0);
    chk("unfill_pc0", 64'(bus.issue0_pc), 64'h1008);
    chk("unfill_inst0", 64'(bus.issue0_inst), 64'd2);

    drive(1'b1, 32'h1018, 2'b11, 64'h7_00000006, 2'd2, 1'b1, 1'b0);
    tick();
    idle();
    chk("stallpush_count", 64'(bus.count), 64'd6);
    chk("stallpush_pc0", 64'(bus.issue0_pc), 64'h1008);
    chk("stallpush_pc1", 64'(bus.issue1_pc), 64'h100C);

    drive(1'b0, 32'h0, 2'b00, 64'h0, 2'd1, 1'b0, 1'b0);
    tick();
    idle();
    chk("pre_flush_count", 64'(bus.count), 64'd5);
    chk("pre_flush_pc0", 64'(bus.issue0_pc), 64'h100C);

    // Flush beats push and pop
    drive(1'b1, 32'h9000, 2'b11, 64'h9_00000008, 2'd2, 1'b0, 1'b1);
    tick();
    idle();
    chk("flush_count", 64'(bus.count), 64'd0);
    chk("flush_v0", 64'(bus.issue0_valid), 64'd0);
    chk("flush_v1", 64'(bus.issue1_valid), 64'd0);
    chk("flush_stallreq", 64'(bus.stallreq_for_fifo), 64'd0);

    drive(1'b1, 32'h2000, 2'b01, 64'h3333_00002222, 2'd0, 1'b0, 1'b0);
    tick();
    idle();
    chk("restart_count", 64'(bus.count), 64'd1);
    chk("restart_pc0", 64'(bus.issue0_pc), 64'h2000);
    chk("restart_inst0", 64'(bus.issue0_inst), 64'h2222);
    drive(1'b0, 32'h0, 2'b00, 64'h0, 2'd1, 1'b0, 1'b0);
    tick();

    // Steady state: push two, pop two, across several wraps
    drive(1'b1, 32'h3000, 2'b11, 64'h5001_00005000, 2'd0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 20; k++) begin
      pc_e = 32'h3000 + 32'(8 * (k + 1));
      lo_e = 32'h5000 + 32'(2 * (k + 1));
      drive(1'b1, pc_e, 2'b11, {lo_e + 32'd1, lo_e}, 2'd2, 1'b0, 1'b0);
      tick();
      chk("steady_count", 64'(bus.count), 64'd2);
      chk("steady_pc0", 64'(bus.issue0_pc), 64'(pc_e));
      chk("steady_pc1", 64'(bus.issue1_pc), 64'(pc_e + 32'd4));
      chk("steady_inst1", 64'(bus.issue1_inst), 64'(lo_e + 32'd1));
    end
    drive(1'b0, 32'h0, 2'b00, 64'h0, 2'd2, 1'b0, 1'b0);
    tick();
    idle();
    chk("drain_count", 64'(bus.count), 64'd0);

    // Push into empty buffer while decode asks for two
    drive(1'b1, 32'h4000, 2'b11, 64'h4B_0000004A, 2'd2, 1'b0, 1'b0);
    #1;
`ifdef INST_BUF_BYPASS_EN
    chk("byp_v0", 64'(bus.issue0_valid), 64'd1);
    chk("byp_v1", 64'(bus.issue1_valid), 64'd1);
    chk("byp_pc0", 64'(bus.issue0_pc), 64'h4000);
    chk("byp_pc1", 64'(bus.issue1_pc), 64'h4004);
    chk("byp_inst1", 64'(bus.issue1_inst), 64'h4B);
    tick();
    idle();
    chk("byp_count", 64'(bus.count), 64'd0);
`else
    chk("nobyp_v0", 64'(bus.issue0_valid), 64'd0);
    tick();
    idle();
    chk("nobyp_count", 64'(bus.count), 64'd2);
    chk("nobyp_pc0", 64'(bus.issue0_pc), 64'h4000);
    drive(1'b0, 32'h0, 2'b00, 64'h0, 2'd2, 1'b0, 1'b0);
    tick();
    idle();
`endif

    // Reset with contents present
    drive(1'b1, 32'h5000, 2'b11, 64'h1_00000000, 2'd0, 1'b0, 1'b0);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_count", 64'(bus.count), 64'd0);
    chk("rst2_v0", 64'(bus.issue0_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
